// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction memory req/ack port, decoder valid/ready port, redirect input.
// FETCH_MISALIGN_TRAP_EN adds the o_misaligned status line.
interface instr_fetch_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_opcode;
  logic [31:0] o_pc;
  logic        i_redirect;
  logic [31:0] i_redirect_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        o_misaligned;
`endif

  modport master (
    output o_imem_req, o_imem_addr, o_valid, o_opcode, o_pc,
    input  i_imem_ack, i_imem_rdata, i_ready, i_redirect, i_redirect_addr
`ifdef FETCH_MISALIGN_TRAP_EN
    , output o_misaligned
`endif
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_valid, o_opcode, o_pc,
    output i_imem_ack, i_imem_rdata, i_ready, i_redirect, i_redirect_addr
`ifdef FETCH_MISALIGN_TRAP_EN
    , input o_misaligned
`endif
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem request, OUT+SKID output queue, redirect flush/discard.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of masking them.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            i_clk,
  input logic            i_rst_n,
  instr_fetch_if.master  bus
);

  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] fetch_pc;
  logic        out_v, skid_v;
  logic [31:0] out_op, out_pc, skid_op, skid_pc;
  logic        discard;
  logic        mis_q;

  logic        ack_fire, consume, out_free, take, req_free, launch_ok;
  logic        n_out_v, n_skid_v, tgt_bad;
  logic [31:0] tgt, pc_after;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt     = bus.i_redirect_addr;
  assign tgt_bad = |bus.i_redirect_addr[1:0];
  assign bus.o_misaligned = mis_q;
`else
  assign tgt     = bus.i_redirect_addr & ~32'h3;
  assign tgt_bad = 1'b0;
`endif

  assign ack_fire = req_q & bus.i_imem_ack;
  assign consume  = out_v & bus.i_ready;
  assign out_free = ~out_v | consume;
  // Acks of a request issued before a redirect are swallowed here.
  assign take     = ack_fire & ~discard;
  assign req_free = ~req_q | ack_fire;
  assign pc_after = take ? fetch_pc + 32'd4 : fetch_pc;

  always_comb begin
    n_out_v  = out_v;
    n_skid_v = skid_v;
    if (out_free) begin
      if (skid_v) begin
        n_out_v  = 1'b1;
        n_skid_v = take;
      end else begin
        n_out_v  = take;
        n_skid_v = 1'b0;
      end
    end else if (take) begin
      n_skid_v = 1'b1;
    end
  end

  // A new request occupies a slot, so launch only while at least one stays free.
  assign launch_ok = req_free & ~(n_out_v & n_skid_v) & ~mis_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      fetch_pc <= RESET_PC;
      out_v    <= 1'b0;
      skid_v   <= 1'b0;
      out_op   <= 32'h0;
      out_pc   <= 32'h0;
      skid_op  <= 32'h0;
      skid_pc  <= 32'h0;
      discard  <= 1'b0;
      mis_q    <= 1'b0;
    end else if (bus.i_redirect) begin
      out_v    <= 1'b0;
      skid_v   <= 1'b0;
      fetch_pc <= tgt;
      mis_q    <= tgt_bad;
      if (tgt_bad) out_pc <= bus.i_redirect_addr;
      if (req_q && !bus.i_imem_ack) begin
        discard <= 1'b1;
      end else begin
        discard <= 1'b0;
        req_q   <= ~tgt_bad;
        if (!tgt_bad) addr_q <= tgt;
      end
    end else begin
      out_v    <= n_out_v;
      skid_v   <= n_skid_v;
      fetch_pc <= pc_after;
      if (ack_fire) discard <= 1'b0;
      if (out_free) begin
        if (skid_v) begin
          out_op <= skid_op;
          out_pc <= skid_pc;
        end else if (take) begin
          out_op <= bus.i_imem_rdata;
          out_pc <= fetch_pc;
        end
      end
      // SKID is always older than a same-cycle ack, so a new word lands there only behind it.
      if (take && !(out_free && !skid_v)) begin
        skid_op <= bus.i_imem_rdata;
        skid_pc <= fetch_pc;
      end
      if (req_free) begin
        req_q <= launch_ok;
        if (launch_ok) addr_q <= pc_after;
      end
    end
  end

  assign bus.o_imem_req  = req_q;
  assign bus.o_imem_addr = addr_q;
  assign bus.o_valid     = out_v;
  assign bus.o_opcode    = out_op;
  assign bus.o_pc        = out_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: accepted acks push {word, pc}, decoder transfers pop and compare.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [31:0] op;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic        ack_en;
  logic [31:0] stop_at;
  logic        stale;
  logic [31:0] exp_pc;
  logic        hold;
  logic [31:0] hold_pc, hold_op;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Advance one cycle, then play the memory for the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    bus.i_redirect   = 1'b0;
    bus.i_imem_ack   = ack_en && bus.o_imem_req && (bus.o_imem_addr != stop_at);
    bus.i_imem_rdata = bus.i_imem_ack ? word_of(bus.o_imem_addr) : 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    bus.i_redirect      = 1'b1;
    bus.i_redirect_addr = a;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] pc);
    int n = 0;
    while (!bus.o_valid && n < 10) begin
      step();
      n++;
    end
    check({tag, "_v"}, {31'b0, bus.o_valid}, 32'd1);
    check({tag, "_pc"}, bus.o_pc, pc);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stale  = 1'b0;
      exp_pc = 32'h0;
      hold   = 1'b0;
    end else begin
      if (hold) begin
        check("hold_v", {31'b0, bus.o_valid}, 32'd1);
        check("hold_pc", bus.o_pc, hold_pc);
        check("hold_op", bus.o_opcode, hold_op);
      end
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) check("sb_under", 32'(q.size()), 32'd1);
        else begin
          ent_t e;
          e = q.pop_front();
          check("sb_pc", bus.o_pc, e.pc);
          check("sb_op", bus.o_opcode, e.op);
        end
      end
      if (bus.i_redirect) begin
        q.delete();
        stale = bus.o_imem_req && !bus.i_imem_ack;
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_pc = bus.i_redirect_addr;
`else
        exp_pc = bus.i_redirect_addr & ~32'h3;
`endif
      end else if (bus.o_imem_req && bus.i_imem_ack) begin
        if (stale) stale = 1'b0;
        else begin
          check("ack_addr", bus.o_imem_addr, exp_pc);
          q.push_back('{op: word_of(exp_pc), pc: exp_pc});
          exp_pc = exp_pc + 32'd4;
        end
      end
      hold    = bus.o_valid && !bus.i_ready && !bus.i_redirect;
      hold_pc = bus.o_pc;
      hold_op = bus.o_opcode;
    end
  end

  initial begin
    logic [31:0] prev;
    logic        seen;
    rst_n = 1'b0;
    ack_en = 1'b0;
    stop_at = 32'h1;
    bus.i_ready = 1'b0;
    bus.i_redirect = 1'b0;
    bus.i_redirect_addr = 32'h0;
    bus.i_imem_ack = 1'b0;
    bus.i_imem_rdata = 32'h0;
    repeat (3) step();
    check("rst_req", {31'b0, bus.o_imem_req}, 32'd0);
    check("rst_addr", bus.o_imem_addr, 32'h0);
    check("rst_valid", {31'b0, bus.o_valid}, 32'd0);
    check("rst_pc", bus.o_pc, 32'h0);
    check("rst_op", bus.o_opcode, 32'h0);
    rst_n = 1'b1;

    // streaming, one instruction per cycle
    bus.i_ready = 1'b1;
    ack_en = 1'b1;
    step();
    check("t1_req", {31'b0, bus.o_imem_req}, 32'd1);
    check("t1_addr", bus.o_imem_addr, 32'h0);
    check("t1_v0", {31'b0, bus.o_valid}, 32'd0);
    step();
    check("t1_v1", {31'b0, bus.o_valid}, 32'd1);
    check("t1_pc0", bus.o_pc, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("t1_seq", bus.o_pc, 32'(4 * i));
    end

    // reset while a request is outstanding, then decoder stall
    rst_n = 1'b0;
    step();
    step();
    check("t2_rst_req", {31'b0, bus.o_imem_req}, 32'd0);
    check("t2_rst_v", {31'b0, bus.o_valid}, 32'd0);
    check("t2_rst_addr", bus.o_imem_addr, 32'h0);
    rst_n = 1'b1;
    bus.i_ready = 1'b0;
    repeat (6) step();
    check("t2_full_v", {31'b0, bus.o_valid}, 32'd1);
    check("t2_full_req", {31'b0, bus.o_imem_req}, 32'd0);
    check("t2_full_n", 32'(q.size()), 32'd2);
    check("t2_full_pc", bus.o_pc, 32'h0);
    bus.i_ready = 1'b1;
    repeat (8) step();

    // redirect while a fetch is waiting for its ack
    do_reset();
    stop_at = 32'h10;
    begin
      int n = 0;
      while (!(bus.o_imem_req && bus.o_imem_addr == 32'h10) && n < 20) begin
        step();
        n++;
      end
      check("t3_reach", bus.o_imem_addr, 32'h10);
    end
    step();
    redirect_to(32'h100);
    step();
    check("t3_v", {31'b0, bus.o_valid}, 32'd0);
    check("t3_hold_req", {31'b0, bus.o_imem_req}, 32'd1);
    check("t3_hold_addr", bus.o_imem_addr, 32'h10);
    step();
    stop_at = 32'h1;
    step();
    step();
    check("t3_new_req", {31'b0, bus.o_imem_req}, 32'd1);
    check("t3_new_addr", bus.o_imem_addr, 32'h100);
    wait_valid("t3_first", 32'h100);
    repeat (3) step();

    // redirect coinciding with an ack and a consume
    do_reset();
    repeat (5) step();
    check("t4_setup", {31'b0, bus.o_valid & bus.i_ready & bus.o_imem_req & bus.i_imem_ack}, 32'd1);
    redirect_to(32'h300);
    step();
    check("t4_v", {31'b0, bus.o_valid}, 32'd0);
    check("t4_req", {31'b0, bus.o_imem_req}, 32'd1);
    check("t4_addr", bus.o_imem_addr, 32'h300);
    wait_valid("t4_first", 32'h300);
    repeat (3) step();

    // PC wrap at the top of the address space
    redirect_to(32'hFFFF_FFF8);
    step();
    prev = 32'h0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.o_valid) begin
        if (prev == 32'hFFFF_FFFC) begin
          check("t5_wrap", bus.o_pc, 32'h0);
          seen = 1'b1;
        end
        prev = bus.o_pc;
      end
    end
    check("t5_seen", {31'b0, seen}, 32'd1);

`ifdef FETCH_MISALIGN_TRAP_EN
    do_reset();
    repeat (4) step();
    redirect_to(32'h102);
    step();
    check("t6_mis", {31'b0, bus.o_misaligned}, 32'd1);
    check("t6_v", {31'b0, bus.o_valid}, 32'd0);
    check("t6_pc", bus.o_pc, 32'h102);
    repeat (4) step();
    check("t6_noreq", {31'b0, bus.o_imem_req}, 32'd0);
    check("t6_sticky", {31'b0, bus.o_misaligned}, 32'd1);
    redirect_to(32'h200);
    step();
    check("t6_clr", {31'b0, bus.o_misaligned}, 32'd0);
    check("t6_addr", bus.o_imem_addr, 32'h200);
    wait_valid("t6_first", 32'h200);
`else
    do_reset();
    repeat (4) step();
    redirect_to(32'h202);
    step();
    check("t6_mask_addr", bus.o_imem_addr, 32'h200);
    wait_valid("t6_first", 32'h200);
`endif

    ack_en = 1'b0;
    repeat (4) step();
    check("sb_drain", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
